// File: rtl/obj_locate_hub.sv
// Multi-channel object-location capture hub with threshold triggers, exposed over AXI4-Lite.
// Optional build macro OBJ_LOCATE_TIMESTAMP_EN adds a free-running cycle counter and per-channel capture timestamps.
module obj_locate_hub #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  input  logic [31:0]              axil_s_awaddr,
  input  logic [2:0]               axil_s_awprot,
  input  logic                     axil_s_awvalid,
  output logic                     axil_s_awready,
  input  logic [31:0]              axil_s_wdata,
  input  logic [3:0]               axil_s_wstrb,
  input  logic                     axil_s_wvalid,
  output logic                     axil_s_wready,
  output logic [1:0]               axil_s_bresp,
  output logic                     axil_s_bvalid,
  input  logic                     axil_s_bready,
  input  logic [31:0]              axil_s_araddr,
  input  logic [2:0]               axil_s_arprot,
  input  logic                     axil_s_arvalid,
  output logic                     axil_s_arready,
  output logic [31:0]              axil_s_rdata,
  output logic [1:0]               axil_s_rresp,
  output logic                     axil_s_rvalid,
  input  logic                     axil_s_rready,
  output logic [NUM_CH-1:0]        trig,
  output logic                     irq
);

  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'('h100);
  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'('h104);
  localparam logic [ADDR_W-1:0] OFF_THRESH = ADDR_W'('h108);
  localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'('h10C);
  localparam logic [ADDR_W-1:0] OFF_ID     = ADDR_W'('h110);
  localparam logic [ADDR_W-1:0] OFF_CNT    = ADDR_W'('h114);
  localparam logic [31:0]       ID_WORD    = {8'h4C, 8'(NUM_CH), 16'h0002};

  typedef enum logic {RD_AR, RD_R} rd_state_t;
  typedef enum logic [1:0] {WR_AW, WR_W, WR_B} wr_state_t;

  rd_state_t         rd_state;
  wr_state_t         wr_state;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] loc [NUM_CH];
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] irq_mask;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] rd_clr;
  logic [15:0]       thresh;
  logic              ctrl_en;
  logic [31:0]       rd_word;
  logic              rd_is_status;
  logic              ar_fire;
  logic              wr_fire;
  logic              trig_clr;
  logic              unused_bits;

  assign s_axis_tready = {NUM_CH{ctrl_en}};
  assign cap           = s_axis_tvalid & {NUM_CH{ctrl_en}};
  assign axil_s_rresp  = 2'b00;
  assign axil_s_bresp  = 2'b00;
  assign rd_addr       = {axil_s_araddr[ADDR_W-1:2], 2'b00};
  assign ar_fire       = axil_s_arready & axil_s_arvalid;
  assign wr_fire       = axil_s_wready & axil_s_wvalid;
  assign trig_clr      = wr_fire && (wr_addr == OFF_CTRL) && axil_s_wdata[1];
  assign rd_clr        = (ar_fire && rd_is_status) ? status : '0;
  assign unused_bits   = ^{axil_s_awaddr[31:ADDR_W], axil_s_awaddr[1:0], axil_s_araddr[31:ADDR_W],
                           axil_s_araddr[1:0], axil_s_awprot, axil_s_arprot, axil_s_wstrb,
                           axil_s_wdata[31:16]};

`ifdef OBJ_LOCATE_TIMESTAMP_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ts [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) ts[i] <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      for (int i = 0; i < NUM_CH; i++)
        if (cap[i]) ts[i] <= cyc_cnt;
    end
  end
`endif

  // Read-data mux; STATUS is flagged so the bits returned can be cleared on the same handshake
  always_comb begin
    rd_word      = '0;
    rd_is_status = 1'b0;
    if (rd_addr[ADDR_W-1:6] == '0) begin
      for (int i = 0; i < NUM_CH; i++)
        if (rd_addr[5:2] == 4'(i)) rd_word = 32'(loc[i]);
    end
`ifdef OBJ_LOCATE_TIMESTAMP_EN
    if (rd_addr[ADDR_W-1:6] == (ADDR_W-6)'(2)) begin
      for (int i = 0; i < NUM_CH; i++)
        if (rd_addr[5:2] == 4'(i)) rd_word = ts[i];
    end
    if (rd_addr == OFF_CNT) rd_word = cyc_cnt;
`else
    if (rd_addr == OFF_CNT) rd_word = '0;
`endif
    case (rd_addr)
      OFF_STATUS: begin
        rd_word      = 32'(status);
        rd_is_status = 1'b1;
      end
      OFF_CTRL:   rd_word = {31'b0, ctrl_en};
      OFF_THRESH: rd_word = {16'b0, thresh};
      OFF_MASK:   rd_word = 32'(irq_mask);
      OFF_ID:     rd_word = ID_WORD;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state       <= RD_AR;
      axil_s_arready <= 1'b1;
      axil_s_rvalid  <= 1'b0;
      axil_s_rdata   <= '0;
    end else begin
      case (rd_state)
        RD_AR: if (axil_s_arvalid) begin
          axil_s_rdata   <= rd_word;
          axil_s_arready <= 1'b0;
          axil_s_rvalid  <= 1'b1;
          rd_state       <= RD_R;
        end
        RD_R: if (axil_s_rready) begin
          axil_s_rvalid  <= 1'b0;
          axil_s_arready <= 1'b1;
          rd_state       <= RD_AR;
        end
        default: rd_state <= RD_AR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state       <= WR_AW;
      axil_s_awready <= 1'b1;
      axil_s_wready  <= 1'b0;
      axil_s_bvalid  <= 1'b0;
    end else begin
      case (wr_state)
        WR_AW: if (axil_s_awvalid) begin
          wr_addr        <= {axil_s_awaddr[ADDR_W-1:2], 2'b00};
          axil_s_awready <= 1'b0;
          axil_s_wready  <= 1'b1;
          wr_state       <= WR_W;
        end
        WR_W: if (axil_s_wvalid) begin
          axil_s_wready <= 1'b0;
          axil_s_bvalid <= 1'b1;
          wr_state      <= WR_B;
        end
        WR_B: if (axil_s_bready) begin
          axil_s_bvalid  <= 1'b0;
          axil_s_awready <= 1'b1;
          wr_state       <= WR_AW;
        end
        default: wr_state <= WR_AW;
      endcase
    end
  end

  // Capture, sticky status, software registers, triggers and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) loc[i] <= '0;
      status   <= '0;
      ctrl_en  <= 1'b1;
      thresh   <= 16'hFFFF;
      irq_mask <= '0;
      trig     <= '0;
      irq      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) begin
          loc[i]  <= s_axis_tdata[i*DATA_W +: DATA_W];
          trig[i] <= (s_axis_tdata[i*DATA_W +: 16] >= thresh);
        end else if (trig_clr) begin
          trig[i] <= 1'b0;
        end
      end
      status <= (status & ~rd_clr) | cap;
      if (wr_fire) begin
        case (wr_addr)
          OFF_CTRL:   ctrl_en  <= axil_s_wdata[0];
          OFF_THRESH: thresh   <= axil_s_wdata[15:0];
          OFF_MASK:   irq_mask <= axil_s_wdata[NUM_CH-1:0];
          default:    ;
        endcase
      end
      irq <= |(status & irq_mask);
    end
  end

endmodule

// File: tb/tb_obj_locate_hub.sv
// Bench for obj_locate_hub: directed scenarios plus randomized traffic against a register-level model.
module tb_obj_locate_hub;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata = '0;
  logic [NUM_CH-1:0]        s_axis_tvalid = '0;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [31:0]              awaddr = '0;
  logic                     awvalid = 1'b0;
  logic                     awready;
  logic [31:0]              wdata = '0;
  logic                     wvalid = 1'b0;
  logic                     wready;
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready = 1'b0;
  logic [31:0]              araddr = '0;
  logic                     arvalid = 1'b0;
  logic                     arready;
  logic [31:0]              rdata;
  logic [1:0]               rresp;
  logic                     rvalid;
  logic                     rready = 1'b0;
  logic [NUM_CH-1:0]        trig;
  logic                     irq;

  obj_locate_hub #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .axil_s_awaddr(awaddr), .axil_s_awprot(3'b000), .axil_s_awvalid(awvalid), .axil_s_awready(awready),
    .axil_s_wdata(wdata), .axil_s_wstrb(4'hF), .axil_s_wvalid(wvalid), .axil_s_wready(wready),
    .axil_s_bresp(bresp), .axil_s_bvalid(bvalid), .axil_s_bready(bready),
    .axil_s_araddr(araddr), .axil_s_arprot(3'b000), .axil_s_arvalid(arvalid), .axil_s_arready(arready),
    .axil_s_rdata(rdata), .axil_s_rresp(rresp), .axil_s_rvalid(rvalid), .axil_s_rready(rready),
    .trig(trig), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Register-level model of the hub
  logic [31:0]       m_loc [NUM_CH];
  logic [NUM_CH-1:0] m_status, m_trig, m_mask;
  logic              m_en;
  logic [15:0]       m_thresh;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) m_loc[i] = '0;
    m_status = '0; m_trig = '0; m_mask = '0; m_en = 1'b1; m_thresh = 16'hFFFF;
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    if (a < 32'(4 * NUM_CH)) return m_loc[idx];
    case (a)
      32'h100: return 32'(m_status);
      32'h104: return {31'b0, m_en};
      32'h108: return {16'b0, m_thresh};
      32'h10C: return 32'(m_mask);
      32'h110: return 32'h4C040002;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0: return awready;
      1: return wready;
      2: return bvalid;
      default: return arready;
    endcase
  endfunction

  task automatic wait_sig(input int which, input string tag);
    int n = 0;
    while (!sig(which) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {31'b0, sig(which)}, 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    wait_sig(3, "arready_wait");
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_lat", {31'b0, rvalid}, 32'd1);
    chk("rresp", {30'b0, rresp}, 32'd0);
    data = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    wait_sig(0, "awready_wait");
    @(posedge clk); #1;
    awvalid = 1'b0;
    wait_sig(1, "wready_wait");
    @(posedge clk); #1;
    wvalid = 1'b0;
    wait_sig(2, "bvalid_wait");
    chk("bresp", {30'b0, bresp}, 32'd0);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
    axi_write(addr, data);
    case (addr)
      32'h104: begin m_en = data[0]; if (data[1]) m_trig = '0; end
      32'h108: m_thresh = data[15:0];
      32'h10C: m_mask = data[NUM_CH-1:0];
      default: ;
    endcase
    chk("trig_after_wr", 32'(trig), 32'(m_trig));
    chk("irq_after_wr", 32'(irq), 32'(|(m_status & m_mask)));
  endtask

  task automatic reg_read_chk(input string tag, input logic [31:0] addr);
    logic [31:0] got, exp;
    exp = exp_read(addr);
    axi_read(addr, got);
    chk(tag, got, exp);
    if (addr == 32'h100) m_status = '0;
    chk("irq_after_rd", 32'(irq), 32'(|(m_status & m_mask)));
  endtask

  task automatic capture(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*DATA_W-1:0] data);
    s_axis_tdata = data; s_axis_tvalid = mask;
    chk("tready", 32'(s_axis_tready), 32'({NUM_CH{m_en}}));
    @(posedge clk); #1;
    s_axis_tvalid = '0;
    if (m_en) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (mask[ch]) begin
          m_loc[ch]    = data[ch*DATA_W +: DATA_W];
          m_status[ch] = 1'b1;
          m_trig[ch]   = (data[ch*DATA_W +: 16] >= m_thresh);
        end
      end
    end
    chk("trig_after_cap", 32'(trig), 32'(m_trig));
    @(posedge clk); #1;
    chk("irq_after_cap", 32'(irq), 32'(|(m_status & m_mask)));
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] rand_data();
    logic [NUM_CH*DATA_W-1:0] d;
    for (int ch = 0; ch < NUM_CH; ch++)
      d[ch*DATA_W +: DATA_W] = {16'($urandom), 16'($urandom_range(0, 256))};
    return d;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_CH*DATA_W-1:0] d;
    logic [31:0] addrs [13];
    logic [31:0] a;
    addrs = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h080, 32'h100,
              32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h200};
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and identity
    chk("rst_arready", {31'b0, arready}, 32'd1);
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_awready", {31'b0, awready}, 32'd1);
    chk("rst_wready", {31'b0, wready}, 32'd0);
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'hF);
    reg_read_chk("id", 32'h110);
    reg_read_chk("thresh_rst", 32'h108);

    // Single capture and clear-on-read STATUS
    d = '0; d[2*DATA_W +: DATA_W] = 32'h00200080;
    capture(4'b0100, d);
    reg_read_chk("loc2", 32'h008);
    reg_read_chk("status_first", 32'h100);
    reg_read_chk("status_second", 32'h100);

    // Threshold trigger and trigger clear
    reg_write(32'h108, 32'h40);
    d = '0; d[0 +: DATA_W] = 32'h00000050; d[DATA_W +: DATA_W] = 32'h00000030;
    capture(4'b0011, d);
    chk("trig_thresh", 32'(trig), 32'h1);
    reg_write(32'h104, 32'h3);
    chk("trig_cleared", 32'(trig), 32'h0);

    // Capture coinciding with the STATUS read handshake
    reg_read_chk("status_pre", 32'h100);
    araddr = 32'h100; arvalid = 1'b1; rready = 1'b1;
    d = '0; d[3*DATA_W +: DATA_W] = 32'h00AA0010;
    s_axis_tdata = d; s_axis_tvalid = 4'b1000;
    chk("coinc_arready", {31'b0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; s_axis_tvalid = '0;
    m_loc[3] = 32'h00AA0010; m_trig[3] = (16'h0010 >= m_thresh);
    chk("coinc_rvalid", {31'b0, rvalid}, 32'd1);
    chk("coinc_rdata", rdata, 32'(m_status));
    m_status = 4'b1000;
    @(posedge clk); #1;
    rready = 1'b0;
    reg_read_chk("coinc_status_kept", 32'h100);
    reg_read_chk("coinc_loc3", 32'h00C);

    // Capture disabled, then interrupt
    reg_write(32'h104, 32'h0);
    capture(4'b1111, rand_data());
    for (int i = 0; i < NUM_CH; i++) reg_read_chk("loc_held", 32'(4 * i));
    reg_write(32'h10C, 32'h1);
    reg_write(32'h104, 32'h1);
    d = '0; d[0 +: DATA_W] = 32'h00010005;
    capture(4'b0001, d);
    chk("irq_rise", {31'b0, irq}, 32'd1);
    reg_read_chk("irq_status", 32'h100);
    chk("irq_drop", {31'b0, irq}, 32'd0);

    // Randomized traffic
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 5))
        0, 1: capture(4'($urandom_range(1, 15)), rand_data());
        2: reg_write(32'h108, $urandom_range(0, 256));
        3: reg_write(32'h104, {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
        4: reg_write(32'h10C, 32'($urandom_range(0, 15)));
        default: begin
          a = addrs[$urandom_range(0, 12)];
          reg_read_chk("rand_rd", a);
        end
      endcase
    end
    for (int i = 0; i < NUM_CH; i++) reg_read_chk("final_loc", 32'(4 * i));
    reg_read_chk("final_status", 32'h100);

    // Write handshake ordering, bready back-pressure, reset in B
    awaddr = 32'h108; wdata = 32'h1234; wvalid = 1'b1; awvalid = 1'b0; bready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("w_stall_wready", {31'b0, wready}, 32'd0);
      chk("w_stall_awready", {31'b0, awready}, 32'd1);
    end
    awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("aw_to_w", {31'b0, wready}, 32'd1);
    chk("aw_no_b", {31'b0, bvalid}, 32'd0);
    @(posedge clk); #1;
    wvalid = 1'b0;
    m_thresh = 16'h1234;
    chk("w_to_b", {31'b0, bvalid}, 32'd1);
    chk("b_wready", {31'b0, wready}, 32'd0);
    repeat (5) begin
      @(posedge clk); #1;
      chk("b_hold", {31'b0, bvalid}, 32'd1);
      chk("b_awready", {31'b0, awready}, 32'd0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("b_done", {31'b0, bvalid}, 32'd0);
    chk("b_back_aw", {31'b0, awready}, 32'd1);
    reg_read_chk("thresh_written", 32'h108);

    awaddr = 32'h10C; wdata = 32'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("b_before_rst", {31'b0, bvalid}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_b_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_b_awready", {31'b0, awready}, 32'd1);
    chk("rst_b_wready", {31'b0, wready}, 32'd0);
    chk("rst_b_arready", {31'b0, arready}, 32'd1);
    chk("rst_b_trig", 32'(trig), 32'd0);
    reg_read_chk("mask_after_rst", 32'h10C);
    reg_read_chk("thresh_after_rst", 32'h108);
    reg_write(32'h10C, 32'h2);
    reg_read_chk("mask_post", 32'h10C);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
